// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the 4-bit execute stage.
// State encodings, ALU mode values and the latched command record.
package alu_exec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_EX   = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  localparam logic MODE_LOGIC = 1'b1;
  localparam logic MODE_ARITH = 1'b0;

  typedef struct packed {
    logic [3:0] sel;
    logic       mode;
    logic       cin;
    logic [3:0] raddr;
    logic [3:0] waddr;
    logic       wb_en;
  } cmd_t;

endpackage

// File: rtl/alu_exec_if.sv
// Command/status and register-file bus of the execute stage.
// master = sequencer + register file side, slave = alu_exec.
interface alu_exec_if;
  logic       start;
  logic [3:0] sel;
  logic       mode;
  logic       cin;
  logic [3:0] raddr;
  logic [3:0] waddr;
  logic       wb_en;
  logic [3:0] rf_dato;
  logic       rf_we;
  logic [3:0] rf_addr;
  logic [3:0] rf_dati;
  logic [3:0] acc;
  logic       cy;
  logic       zero;
  logic       busy;
  logic       done;

  modport slave (
    input  start, sel, mode, cin, raddr, waddr, wb_en, rf_dato,
    output rf_we, rf_addr, rf_dati, acc, cy, zero, busy, done
  );

  modport master (
    output start, sel, mode, cin, raddr, waddr, wb_en, rf_dato,
    input  rf_we, rf_addr, rf_dati, acc, cy, zero, busy, done
  );
endinterface

// File: rtl/alu_exec_alu181.sv
// 74181-style 4-bit function unit, purely combinational.
// X/Y are the generate/propagate-like terms the select lines build.
module alu181
  import alu_exec_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] sel,
  input  logic       mode,
  input  logic       cin,
  output logic [3:0] f,
  output logic       cout
);

  logic [3:0] x;
  logic [3:0] y;
  logic [4:0] sum;

  always_comb begin
    x    = a | (sel[0] ? b : 4'h0) | (sel[1] ? ~b : 4'h0);
    y    = (sel[2] ? (a & ~b) : 4'h0) | (sel[3] ? (a & b) : 4'h0);
    sum  = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    f    = sum[3:0];
    cout = sum[4];
    unique case (mode)
      MODE_LOGIC: begin
        f    = ~(x ^ y);
        cout = 1'b0;
      end
      MODE_ARITH: begin
        f    = sum[3:0];
        cout = sum[4];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Execute stage: latches a command, reads B from the register file,
// updates accumulator/flags and optionally writes the result back.
//
// state   | meaning
// --------+-----------------------------------------------------
// ST_IDLE | waiting for start
// ST_RD   | rf_addr = raddr, rf_dato captured into B at end
// ST_EX   | acc/cy/zero take the ALU result at end
// ST_WB   | rf_addr = waddr, rf_we = wb_en; may accept next start
module alu_exec
  import alu_exec_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  alu_exec_if.slave     bus
);

  state_e     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic [3:0] b_q, b_d;
  logic [3:0] acc_q, acc_d;
  logic       cy_q, cy_d;
  logic       zero_q, zero_d;

  logic       accept;
  cmd_t       cmd_in;
  logic [3:0] alu_f;
  logic       alu_cout;

  alu181 u_alu (
    .a    (acc_q),
    .b    (b_q),
    .sel  (cmd_q.sel),
    .mode (cmd_q.mode),
    .cin  (cmd_q.cin),
    .f    (alu_f),
    .cout (alu_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      b_q     <= 4'h0;
      acc_q   <= 4'h0;
      cy_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cy_q    <= cy_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    cmd_in.sel   = bus.sel;
    cmd_in.mode  = bus.mode;
    cmd_in.cin   = bus.cin;
    cmd_in.raddr = bus.raddr;
    cmd_in.waddr = bus.waddr;
    cmd_in.wb_en = bus.wb_en;
  end

  // Starts arriving in RD/EX are dropped so the latched command stays intact.
  assign accept = bus.start && ((state_q == ST_IDLE) || (state_q == ST_WB));

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cy_d    = cy_q;
    zero_d  = zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_d   = cmd_in;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        b_d     = bus.rf_dato;
        state_d = ST_EX;
      end
      ST_EX: begin
        acc_d   = alu_f;
        cy_d    = alu_cout;
        zero_d  = (alu_f == 4'h0);
        state_d = ST_WB;
      end
      ST_WB: begin
        if (accept) begin
          cmd_d   = cmd_in;
          state_d = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.rf_addr = (state_q == ST_WB) ? cmd_q.waddr : cmd_q.raddr;
  assign bus.rf_we   = (state_q == ST_WB) && cmd_q.wb_en;
  assign bus.rf_dati = acc_q;
  assign bus.acc     = acc_q;
  assign bus.cy      = cy_q;
  assign bus.zero    = zero_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_WB);

endmodule

// File: tb/tb_alu_exec.sv
// Randomized + directed bench for alu_exec with a behavioural register
// file and a reference model of the accumulator/flags/write-back.
module tb_alu_exec;

  logic clk = 1'b0;
  logic rst;

  alu_exec_if bus ();

  alu_exec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] rf     [16];
  logic [3:0] exp_rf [16];
  logic       poke_we;
  logic [3:0] poke_addr;
  logic [3:0] poke_data;

  always @(posedge clk) begin
    if (bus.rf_we)    rf[bus.rf_addr] <= bus.rf_dati;
    else if (poke_we) rf[poke_addr]   <= poke_data;
  end

  assign bus.rf_dato = rf[bus.rf_addr];

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] m_acc;
  logic       m_cy;
  logic       m_zero;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {carry, result} straight from the X/Y definitions with integer math.
  function automatic int ref_f(input int a, input int b, input int s, input int m, input int c);
    int x, y, r;
    x = a;
    if ((s & 1) != 0) x = x | b;
    if ((s & 2) != 0) x = x | (~b & 15);
    y = 0;
    if ((s & 4) != 0) y = y | (a & ~b & 15);
    if ((s & 8) != 0) y = y | (a & b);
    if (m != 0) begin
      r = ~(x ^ y) & 15;
    end else begin
      r = x + y + c;
    end
    return r;
  endfunction

  task automatic set_cmd(input logic [3:0] s, input logic m, input logic c,
                         input logic [3:0] ra, input logic [3:0] wa, input logic we);
    bus.sel   = s;
    bus.mode  = m;
    bus.cin   = c;
    bus.raddr = ra;
    bus.waddr = wa;
    bus.wb_en = we;
  endtask

  task automatic poke(input logic [3:0] addr, input logic [3:0] data);
    poke_we   = 1'b1;
    poke_addr = addr;
    poke_data = data;
    exp_rf[addr] = data;
    @(posedge clk);
    @(negedge clk);
    poke_we = 1'b0;
  endtask

  // n commands with start held high; glitch toggles inputs during RD/EX.
  task automatic run_cmd(input logic [3:0] s, input logic m, input logic c,
                         input logic [3:0] ra, input logic [3:0] wa, input logic we,
                         input int n, input bit glitch);
    int r;
    set_cmd(s, m, c, ra, wa, we);
    bus.start = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("rd_busy", int'(bus.busy), 1);
      check_val("rd_done", int'(bus.done), 0);
      check_val("rd_we", int'(bus.rf_we), 0);
      check_val("rd_addr", int'(bus.rf_addr), int'(ra));
      r = ref_f(int'(m_acc), int'(exp_rf[ra]), int'(s), int'(m), int'(c));
      if (glitch) begin
        set_cmd(~s, ~m, ~c, ra + 4'd1, wa + 4'd1, ~we);
        bus.start = 1'b1;
      end else if (n == 1) begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check_val("ex_busy", int'(bus.busy), 1);
      check_val("ex_done", int'(bus.done), 0);
      check_val("ex_we", int'(bus.rf_we), 0);
      check_val("ex_addr", int'(bus.rf_addr), int'(ra));
      @(posedge clk);
      @(negedge clk);
      m_acc  = 4'(r);
      m_cy   = (r > 15);
      m_zero = ((r & 15) == 0);
      check_val("wb_acc", int'(bus.acc), int'(m_acc));
      check_val("wb_cy", int'(bus.cy), int'(m_cy));
      check_val("wb_zero", int'(bus.zero), int'(m_zero));
      check_val("wb_done", int'(bus.done), 1);
      check_val("wb_busy", int'(bus.busy), 1);
      check_val("wb_we", int'(bus.rf_we), int'(we));
      check_val("wb_addr", int'(bus.rf_addr), int'(wa));
      check_val("wb_dati", int'(bus.rf_dati), int'(m_acc));
      set_cmd(s, m, c, ra, wa, we);
      bus.start = (k < n - 1);
      if (we) exp_rf[wa] = m_acc;
    end
    @(posedge clk);
    @(negedge clk);
    check_val("idle_busy", int'(bus.busy), 0);
    check_val("idle_done", int'(bus.done), 0);
    check_val("idle_we", int'(bus.rf_we), 0);
    check_val("rf_wb", int'(rf[wa]), int'(exp_rf[wa]));
  endtask

  task automatic reset_mid(input logic [3:0] ra, input logic [3:0] wa);
    set_cmd(4'h9, 1'b0, 1'b1, ra, wa, 1'b1);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("rst_pre_busy", int'(bus.busy), 1);
    check_val("rst_pre_we", int'(bus.rf_we), 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", int'(bus.busy), 0);
    check_val("rst_done", int'(bus.done), 0);
    check_val("rst_acc", int'(bus.acc), 0);
    check_val("rst_cy", int'(bus.cy), 0);
    check_val("rst_zero", int'(bus.zero), 0);
    check_val("rst_we", int'(bus.rf_we), 0);
    rst    = 1'b0;
    m_acc  = 4'h0;
    m_cy   = 1'b0;
    m_zero = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("rst_post_we", int'(bus.rf_we), 0);
    check_val("rst_post_busy", int'(bus.busy), 0);
    check_val("rst_target", int'(rf[wa]), int'(exp_rf[wa]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit g;
    rst     = 1'b1;
    poke_we = 1'b0;
    poke_addr = 4'h0;
    poke_data = 4'h0;
    bus.start = 1'b0;
    set_cmd(4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    m_acc  = 4'h0;
    m_cy   = 1'b0;
    m_zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_acc", int'(bus.acc), 0);
    check_val("reset_cy", int'(bus.cy), 0);
    check_val("reset_zero", int'(bus.zero), 0);
    check_val("reset_busy", int'(bus.busy), 0);
    check_val("reset_done", int'(bus.done), 0);
    check_val("reset_we", int'(bus.rf_we), 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) poke(4'(i), 4'($urandom_range(0, 15)));

    // load via logic S=A
    poke(4'd2, 4'h7);
    run_cmd(4'hA, 1'b1, 1'b0, 4'd2, 4'd0, 1'b0, 1, 1'b0);
    check_val("t1_acc", int'(bus.acc), 7);

    // 7 + 0xB = 0x12 with write-back to rf[5]
    poke(4'd3, 4'hB);
    run_cmd(4'h9, 1'b0, 1'b0, 4'd3, 4'd5, 1'b1, 1, 1'b0);
    check_val("t2_acc", int'(bus.acc), 2);
    check_val("t2_cy", int'(bus.cy), 1);
    check_val("t2_rf5", int'(rf[5]), 2);

    // 5 - 5 - 1 + 1 = 0, carry set
    poke(4'd4, 4'h5);
    run_cmd(4'hA, 1'b1, 1'b0, 4'd4, 4'd0, 1'b0, 1, 1'b0);
    run_cmd(4'h6, 1'b0, 1'b1, 4'd4, 4'd0, 1'b0, 1, 1'b0);
    check_val("t3_acc", int'(bus.acc), 0);
    check_val("t3_cy", int'(bus.cy), 1);
    check_val("t3_zero", int'(bus.zero), 1);

    // held start, read-after-write on the same address
    poke(4'd6, 4'h3);
    run_cmd(4'h9, 1'b0, 1'b1, 4'd6, 4'd6, 1'b1, 3, 1'b0);

    // starts in RD/EX ignored
    run_cmd(4'h9, 1'b0, 1'b0, 4'd2, 4'd7, 1'b1, 1, 1'b1);

    poke(4'd8, 4'hC);
    reset_mid(4'd2, 4'd8);

    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(1, 3);
      g = (n == 1) && ($urandom_range(0, 3) == 0);
      run_cmd(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              n, g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute stage of the 4-bit datapath. Accepts one command per start pulse and reads operand B from the 16x4 register file. It computes a 74181-style function of accumulator A and B, updates the accumulator and flags, and optionally writes the result back to the register file. It sits directly between the sequencer (command source) and the register file: it drives the file's `we`/`addr`/`dati` and consumes its combinational `dato`.

## Interface
- No parameters; all widths fixed at 4 bits.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  command strobe; sampled on rising edge.
- `sel`  in  4  ALU function select S[3:0].
- `mode`  in  1  1 = logic, 0 = arithmetic.
- `cin`  in  1  carry in, active-high; arithmetic only.
- `raddr`  in  4  register file address of operand B.
- `waddr`  in  4  write-back address.
- `wb_en`  in  1  write result back to `waddr`.
- `rf_dato`  in  4  register file read data (combinational).
- `rf_we`  out  1  register file write enable.
- `rf_addr`  out  4  register file address.
- `rf_dati`  out  4  register file write data.
- `acc`  out  4  accumulator.
- `cy`  out  1  carry flag.
- `zero`  out  1  zero flag.
- `busy`  out  1  command in progress.
- `done`  out  1  final cycle of a command.

## Operation
- Command latch: when a start is accepted, `sel`, `mode`, `cin`, `raddr`, `waddr` and `wb_en` are registered. The command uses only these registered values.
- FSM states: IDLE, RD, EX, WB.
  - IDLE→RD on accepted start.
  - RD→EX unconditionally.
  - EX→WB unconditionally.
  - WB→RD if start is accepted in WB; otherwise WB→IDLE.
- Start acceptance:
  - start is accepted only in IDLE or WB.
  - start in RD or EX is ignored, with no effect on state or latches.
- RD: `rf_addr` = latched raddr; `rf_dato` is registered into the B operand at the end of RD.
- EX: result is computed from A = `acc` and B = latched B. At the end of EX:
  - `acc` ← result.
  - `cy` ← carry out.
  - `zero` ← (result == 0).
- Function (X, Y are 4-bit intermediate terms):
  - X = A | (S0 ? B : 0) | (S1 ? ~B : 0).
  - Y = (S2 ? A&~B : 0) | (S3 ? A&B : 0).
  - Arithmetic: 5-bit sum = X + Y + cin; result = sum[3:0]; carry = sum[4]. Examples: S=0 → A, S=6 → A−B−1+cin, S=9 → A+B+cin, S=F → A−1+cin.
  - Logic: result = ~(X ^ Y); carry = 0. Examples: S=0 → ~A, S=6 → A^B, S=A → B (load), S=B → A&B, S=F → A.
- WB: `rf_addr` = latched waddr; `rf_dati` = `acc`; `rf_we` = latched wb_en. The register file is written on the edge that ends WB.
- In IDLE, RD and EX: `rf_we` = 0 and `rf_addr` = latched raddr.
- `busy` = (state != IDLE); `done` = (state == WB). Both are decoded from the state.
- Reset (at any point, including mid-command):
  - Outputs: state = IDLE, `acc` = 0, `cy` = 0, `zero` = 0, `rf_we` = 0, `busy` = 0, `done` = 0.
  - Internal registers: latched command = 0, B = 0.
  - An interrupted command performs no write-back.

## Timing
- Start sampled at edge k:
  - RD during cycle k..k+1.
  - `acc`/flags update at edge k+2.
  - `done` and `rf_we` are high during cycle k+2..k+3.
  - The register file is written at edge k+3.
- Latency start→`acc` valid: 2 edges; start→write-back: 3 edges.
- Back-to-back commands: a start sampled at edge k+3 (in WB) enters RD immediately, giving one command per 3 cycles.
- RD of the following command occurs after the WB edge, so read-after-write through the register file returns the new value.
- `rf_addr` switches combinationally with state. The register file's combinational `dato` must settle within RD.

## Structure
- FSM state encodings (2-bit) and the MODE_LOGIC/MODE_ARITH constants go in the shared define file.
- One combinational sub-module, `alu181`:
  - Inputs: a, b, sel, mode, cin.
  - Outputs: f[3:0], cout.
- The FSM, command latches, accumulator and flags are in `alu_exec`.

## Test plan
- Reset, then register file model rf[2]=7. Command mode=1, sel=A, raddr=2, wb_en=0 → `acc`=7, `cy`=0, `zero`=0 at edge k+2; `rf_we` never high.
- With `acc`=7 and rf[3]=B: command mode=0, sel=9, cin=0, raddr=3, wb_en=1, waddr=5 → `acc`=2, `cy`=1; rf[5]=2 after edge k+3; `done` high exactly one cycle.
- With `acc`=5 and rf[4]=5: command mode=0, sel=6, cin=1, raddr=4 → `acc`=0, `cy`=1, `zero`=1.
- Start held high continuously: commands are accepted at edges k, k+3, k+6; `busy` stays high; the second command reads the value written by the first (same address).
- Start pulses during RD and during EX are ignored: the latched `sel`/`raddr` are unchanged and the result matches the first command only.
- Reset asserted in EX after a wb_en=1 command → the next cycle shows IDLE, `acc`=0, `cy`=0, `zero`=0, `busy`=0; `rf_we` never asserts and the target register is unchanged.
